mem_wb_stage_v2: RTL

Parametrised successor of the MEM/WB pipeline register for the MIPS core. It adds valid tracking, stall, flush/bubble insertion, and reg-write qualification by valid. It also adds a retired-instruction counter and a registered debug-readback port for the debug unit. It sits between the data-memory stage and the writeback mux and register file, and it honours the debug-unit clock enable.

---
 rtl/mem_wb_stage_v2.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_wb_stage_v2.sv
// mem_wb_stage_v2: MEM/WB pipeline register with valid tracking,
// stall/flush, retire counter and registered debug readback.
module mem_wb_stage_v2 #(
  parameter int NB_REG  = 32,
  parameter int NB_CTRL = 4,
  parameter int NB_ADDR = 5,
  parameter int RW_BIT  = 0,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_read_data,
  input  logic [NB_REG-1:0]  i_alu_res,
  input  logic [NB_ADDR-1:0] i_data_addr,
  input  logic [NB_CTRL-1:0] i_control,
  input  logic               i_cnt_clr,
  input  logic [2:0]         i_dbg_sel,
  output logic               o_valid,
  output logic [NB_REG-1:0]  o_pc_eight,
  output logic [NB_REG-1:0]  o_read_data,
  output logic [NB_REG-1:0]  o_alu_res,
  output logic [NB_ADDR-1:0] o_data_addr,
  output logic [NB_CTRL-1:0] o_control,
  output logic               o_reg_write,
  output logic [NB_CNT-1:0]  o_retired,
  output logic [NB_REG-1:0]  o_dbg_data
);

  localparam int NB_PK = NB_ADDR + NB_CTRL + 1;

  logic               valid_q;
  logic [NB_REG-1:0]  pc_q;
  logic [NB_REG-1:0]  rd_q;
  logic [NB_REG-1:0]  alu_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_CTRL-1:0] ctrl_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_REG-1:0]  dbg_q;
  logic [NB_REG-1:0]  dbg_nxt;
  logic [NB_PK-1:0]   pk;
  logic               bubble;
  logic               adv;

  assign bubble = i_dunit_clk_en & i_flush;
  assign adv    = i_dunit_clk_en & ~i_flush & ~i_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
    end else if (adv) begin
      valid_q <= i_valid;
      pc_q    <= i_pc_eight;
      rd_q    <= i_read_data;
      alu_q   <= i_alu_res;
      addr_q  <= i_data_addr;
      ctrl_q  <= i_control;
    end
  end

  // Clear is deliberately not gated by the debug clock enable.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_cnt_clr) begin
      cnt_q <= '0;
    end else if (adv && i_valid) begin
      cnt_q <= cnt_q + NB_CNT'(1);
    end
  end

  assign pk = {addr_q, ctrl_q, valid_q};

  always_comb begin
    dbg_nxt = '0;
    unique case (i_dbg_sel)
      3'd0:    dbg_nxt = pc_q;
      3'd1:    dbg_nxt = rd_q;
      3'd2:    dbg_nxt = alu_q;
      3'd3:    dbg_nxt = NB_REG'(pk);
      3'd4:    dbg_nxt = NB_REG'(cnt_q);
      default: dbg_nxt = '0;
    endcase
  end

  // Readback runs every cycle so a halted core can still be inspected.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dbg_q <= '0;
    end else begin
      dbg_q <= dbg_nxt;
    end
  end

  assign o_valid     = valid_q;
  assign o_pc_eight  = pc_q;
  assign o_read_data = rd_q;
  assign o_alu_res   = alu_q;
  assign o_data_addr = addr_q;
  assign o_control   = ctrl_q;
  assign o_reg_write = ctrl_q[RW_BIT] & valid_q;
  assign o_retired   = cnt_q;
  assign o_dbg_data  = dbg_q;

endmodule
